// File: rtl/crc_tx_pkg.sv
// crc_tx_pkg: shared state type and constants for the CRC frame
// transmitter and its matching receiver.
package crc_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LEN,
    S_DATA,
    S_CRC,
    S_GAP
  } tx_state_t;

  localparam int unsigned LEN_BYTE_W = 8;

  localparam logic [15:0] DEF_CRC_POLY = 16'h1021;
  localparam logic [15:0] DEF_CRC_INIT = 16'hFFFF;
  localparam logic [7:0]  DEF_PREAMBLE = 8'hA5;

endpackage

// File: rtl/crc_serial.sv
// crc_serial: bit-serial, non-reflected CRC register.
// init reloads the seed; en folds in one bit MSB-first.
module crc_serial
  import crc_tx_pkg::*;
#(
  parameter int unsigned      CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(DEF_CRC_POLY),
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(DEF_CRC_INIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= (crc << 1) ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/crc_frame_tx.sv
// crc_frame_tx: serialises preamble, length, payload and CRC
// MSB-first on an idle-high line, followed by a busy gap.
module crc_frame_tx
  import crc_tx_pkg::*;
#(
  parameter int unsigned      DATA_BYTES   = 16,
  parameter int unsigned      CRC_W        = 16,
  parameter logic [CRC_W-1:0] CRC_POLY     = CRC_W'(DEF_CRC_POLY),
  parameter logic [CRC_W-1:0] CRC_INIT     = CRC_W'(DEF_CRC_INIT),
  parameter logic [7:0]       PREAMBLE     = DEF_PREAMBLE,
  parameter int unsigned      CLKS_PER_BIT = 1,
  parameter int unsigned      GAP_BITS     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tx_start,
  input  logic [DATA_BYTES*8-1:0]           tx_payload,
  input  logic [$clog2(DATA_BYTES+1)-1:0]   tx_len,
  input  logic                              test_mode,
  output logic                              tx_line,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic                              tx_err,
  output logic [CRC_W-1:0]                  crc_out
);

  localparam int unsigned PW = DATA_BYTES * 8;
  localparam int unsigned LW = $clog2(DATA_BYTES + 1);
  localparam int unsigned CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned FMAX =
    (GAP_BITS > CRC_W) ? GAP_BITS : CRC_W;
  localparam int unsigned BW = $clog2(FMAX + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(DATA_BYTES);

  tx_state_t state, state_d;

  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [LW-1:0]         byte_cnt;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         len_clamp;
  logic [PW-1:0]         pay_q;
  logic [CRC_W-1:0]      sh_q;
  logic [CRC_W-1:0]      sh_d;
  logic [CRC_W-1:0]      crc;
  logic [LEN_BYTE_W-1:0] len_byte;
  logic                  tmode_q;

  logic accept;
  logic reject;
  logic bit_end;
  logic byte_end;
  logic last_bit;
  logic field_end;
  logic load_len;
  logic load_data;
  logic load_crc;
  logic shift;
  logic line_d;
  logic crc_en;

  // Bytes ride MSB-aligned in the CRC-wide shifter (CRC_W >= 8).
  function automatic logic [CRC_W-1:0] byte_msb(
    input logic [LEN_BYTE_W-1:0] b
  );
    return CRC_W'(b) << (CRC_W - LEN_BYTE_W);
  endfunction

  assign len_byte = LEN_BYTE_W'(len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    len_clamp = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
    bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    byte_end  = bit_end && (bit_cnt == BW'(7));
    last_bit  = 1'b0;
    unique case (state)
      S_PRE, S_LEN:
        last_bit = (bit_cnt == BW'(7));
      S_DATA:
        last_bit = (bit_cnt == BW'(7))
                && (byte_cnt == len_q - LW'(1));
      S_CRC:
        last_bit = (bit_cnt == BW'(CRC_W - 1));
      S_GAP:
        last_bit = (bit_cnt == BW'(GAP_BITS - 1));
      default:
        last_bit = 1'b0;
    endcase
    field_end = bit_end && last_bit;
    accept = (state == S_IDLE) && tx_start
          && (tx_len != '0);
    reject = (state == S_IDLE) && tx_start
          && (tx_len == '0);

    state_d = state;
    unique case (state)
      S_IDLE: if (accept)    state_d = S_PRE;
      S_PRE:  if (field_end) state_d = S_LEN;
      S_LEN:  if (field_end) state_d = S_DATA;
      S_DATA: if (field_end) state_d = S_CRC;
      S_CRC:
        if (field_end)
          state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (field_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    load_len  = field_end && (state == S_PRE);
    load_data = bit_end
             && ((state == S_LEN && last_bit)
             ||  (state == S_DATA && byte_end && !last_bit));
    load_crc  = field_end && (state == S_DATA);
    shift     = bit_end
             && (state inside {S_PRE, S_LEN, S_DATA, S_CRC})
             && !(load_len || load_data || load_crc);

    sh_d = sh_q;
    unique case (1'b1)
      accept:    sh_d = byte_msb(PREAMBLE);
      load_len:  sh_d = byte_msb(len_byte);
      load_data: sh_d = byte_msb(pay_q[PW-1 -: 8]);
      load_crc:  sh_d = crc ^ CRC_W'(tmode_q);
      shift:     sh_d = sh_q << 1;
      default:   sh_d = sh_q;
    endcase

    line_d = (state_d inside {S_PRE, S_LEN, S_DATA, S_CRC})
           ? sh_d[CRC_W-1] : 1'b1;
    // Fold each payload bit in as it is launched onto the line.
    crc_en = (state_d == S_DATA) && (load_data || shift);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
      crc_out  <= '0;
      sh_q     <= '0;
      pay_q    <= '0;
      len_q    <= '0;
      tmode_q  <= 1'b0;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      tx_line <= line_d;
      tx_busy <= (state_d != S_IDLE);
      tx_done <= (state != S_IDLE) && (state_d == S_IDLE);
      tx_err  <= reject;
      sh_q    <= sh_d;
      if (accept) begin
        pay_q    <= tx_payload;
        len_q    <= len_clamp;
        tmode_q  <= test_mode;
        clk_cnt  <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (state != S_IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
        if (bit_end) begin
          if (field_end || (state == S_DATA && byte_end))
            bit_cnt <= '0;
          else
            bit_cnt <= bit_cnt + BW'(1);
          if (state == S_DATA && byte_end)
            byte_cnt <= byte_cnt + LW'(1);
        end
        if (load_data) pay_q <= pay_q << 8;
        if (load_crc)  crc_out <= crc;
      end
    end
  end

  crc_serial #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (accept),
    .en     (crc_en),
    .bit_in (sh_d[CRC_W-1]),
    .crc    (crc)
  );

endmodule

// File: tb/tb_crc_frame_tx.sv
// tb_crc_frame_tx: random and directed frames checked against a
// byte-level frame model kept in the bench.
module tb_crc_frame_tx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tx_start = 1'b0;
  logic [127:0] tx_payload = '0;
  logic [4:0]   tx_len = '0;
  logic         test_mode = 1'b0;
  logic         tx_line, tx_busy, tx_done, tx_err;
  logic [15:0]  crc_out;

  logic         start4 = 1'b0;
  logic [127:0] pay4 = '0;
  logic [4:0]   len4 = '0;
  logic         tm4 = 1'b0;
  logic         line4, busy4, done4, err4;
  logic [15:0]  crc4;

  int n_vec = 0;
  int n_err = 0;

  bit          exp_bits[$];
  logic [15:0] exp_crc;
  int          exp_n;
  logic [15:0] got_crc_tx;
  logic [7:0]  got_len;

  localparam logic [127:0] NOM =
    {72'h313233343536373839, 56'h0};

  always #5 clk = ~clk;

  crc_frame_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .tx_payload (tx_payload),
    .tx_len     (tx_len),
    .test_mode  (test_mode),
    .tx_line    (tx_line),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .crc_out    (crc_out)
  );

  crc_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (start4),
    .tx_payload (pay4),
    .tx_len     (len4),
    .test_mode  (tm4),
    .tx_line    (line4),
    .tx_busy    (busy4),
    .tx_done    (done4),
    .tx_err     (err4),
    .crc_out    (crc4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
  endfunction

  // Whole frame as a bit list; CRC computed a byte at a time.
  function automatic void build_frame(input logic [127:0] p,
                                      input int len_in,
                                      input bit tm);
    logic [15:0] c;
    logic [7:0]  b;
    int          n;
    n = (len_in > 16) ? 16 : len_in;
    c = 16'hFFFF;
    exp_bits.delete();
    push_byte(8'hA5);
    push_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      b = p[127 - 8*i -: 8];
      push_byte(b);
      c = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    for (int k = 15; k >= 0; k--)
      exp_bits.push_back((k == 0) ? (c[0] ^ tm) : c[k]);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b1);
    exp_crc = c;
    exp_n = n;
  endfunction

  task automatic arm(input logic [127:0] p, input int l,
                     input bit tm);
    tx_payload = p;
    tx_len = 5'(l);
    test_mode = tm;
    tx_start = 1'b1;
  endtask

  // Called at a negedge with the start already armed.
  task automatic run_frame(input logic [127:0] p, input int l,
                           input bit tm, input bit hold);
    int nb;
    int lat;
    int crc_pos;
    build_frame(p, l, tm);
    nb = exp_bits.size();
    crc_pos = 16 + 8 * exp_n;
    lat = -1;
    @(posedge clk);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (!hold) begin
        if (i == 0) begin
          tx_start = 1'b0;
          tx_payload = rnd128();
          tx_len = 5'($urandom_range(1, 31));
          test_mode = 1'($urandom);
        end
        if (i == nb / 2) tx_start = 1'b1;
        if (i == nb / 2 + 1) tx_start = 1'b0;
      end
      chk($sformatf("line[%0d]", i), 32'(tx_line),
          32'(exp_bits[i]));
      chk($sformatf("busy[%0d]", i), 32'(tx_busy), 32'd1);
      if (i >= 8 && i < 16)
        got_len = {got_len[6:0], tx_line};
      if (i >= crc_pos && i < crc_pos + 16)
        got_crc_tx = {got_crc_tx[14:0], tx_line};
      if (tx_done && lat < 0) lat = i;
    end
    @(negedge clk);
    if (tx_done && lat < 0) lat = nb;
    chk("done", 32'(tx_done), 32'd1);
    chk("busy_off", 32'(tx_busy), 32'd0);
    chk("line_idle", 32'(tx_line), 32'd1);
    chk("crc_out", 32'(crc_out), 32'(exp_crc));
    chk("latency", lat, 16 + 8 * exp_n + 16 + 2);
  endtask

  initial begin
    logic [127:0] p2;
    int           l2;
    int           lat4;

    repeat (3) @(negedge clk);
    chk("rst_line", 32'(tx_line), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_crc", 32'(crc_out), 32'd0);
    chk("rst_line4", 32'(line4), 32'd1);
    rst_n = 1'b1;

    @(negedge clk);
    arm(NOM, 9, 1'b0);
    run_frame(NOM, 9, 1'b0, 1'b0);
    chk("nom_crc_out", 32'(crc_out), 32'h29B1);
    chk("nom_crc_tx", 32'(got_crc_tx), 32'h29B1);
    chk("nom_len", 32'(got_len), 32'h09);

    @(negedge clk);
    arm(NOM, 9, 1'b1);
    run_frame(NOM, 9, 1'b1, 1'b0);
    chk("tm_crc_tx", 32'(got_crc_tx), 32'h29B0);
    chk("tm_crc_out", 32'(crc_out), 32'h29B1);

    @(negedge clk);
    arm(rnd128(), 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("err_pulse", 32'(tx_err), 32'd1);
    chk("err_busy", 32'(tx_busy), 32'd0);
    chk("err_line", 32'(tx_line), 32'd1);
    tx_start = 1'b0;
    @(negedge clk);
    chk("err_once", 32'(tx_err), 32'd0);
    chk("err_busy2", 32'(tx_busy), 32'd0);

    p2 = rnd128();
    @(negedge clk);
    arm(p2, 31, 1'b0);
    run_frame(p2, 31, 1'b0, 1'b0);
    chk("clamp_len", 32'(got_len), 32'h10);

    @(negedge clk);
    arm(NOM, 9, 1'b0);
    run_frame(NOM, 9, 1'b0, 1'b1);
    p2 = rnd128();
    l2 = $urandom_range(1, 16);
    tx_payload = p2;
    tx_len = 5'(l2);
    test_mode = 1'b0;
    run_frame(p2, l2, 1'b0, 1'b0);

    @(negedge clk);
    arm(NOM, 9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_rst_line", 32'(tx_line), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_line", 32'(tx_line), 32'd1);
    chk("mid_rst_crc", 32'(crc_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_nodone", 32'(tx_done), 32'd0);
    end
    arm(NOM, 9, 1'b0);
    run_frame(NOM, 9, 1'b0, 1'b0);
    chk("post_rst_crc", 32'(crc_out), 32'h29B1);

    for (int r = 0; r < 20; r++) begin
      p2 = rnd128();
      l2 = $urandom_range(1, 20);
      arm(p2, l2, 1'($urandom));
      run_frame(p2, l2, test_mode, 1'b0);
    end

    @(negedge clk);
    pay4 = '0;
    len4 = 5'd1;
    tm4 = 1'b0;
    start4 = 1'b1;
    build_frame(pay4, 1, 1'b0);
    lat4 = -1;
    @(posedge clk);
    for (int i = 0; i < exp_bits.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start4 = 1'b0;
        chk($sformatf("line4[%0d.%0d]", i, k), 32'(line4),
            32'(exp_bits[i]));
        if (done4 && lat4 < 0) lat4 = 4 * i + k;
      end
    end
    @(negedge clk);
    if (done4 && lat4 < 0) lat4 = 168;
    chk("done4", 32'(done4), 32'd1);
    chk("busy4_off", 32'(busy4), 32'd0);
    chk("latency4", lat4, 168);
    chk("crc4", 32'(crc4), 32'(exp_crc));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
